// File: rtl/common.sv
// Shared core types for the MEM stage and its neighbours.
// Contents:
//   BUS_ADDR_W / BUS_DATA_W / BUS_LANES  data-bus geometry
//   msize_t          access size encoding (byte/half/word/dword)
//   mem_state_t      MEM stage FSM states
//   ctl_t            decoded control bits carried down the pipe
//   execute_data_t   EX/MEM register payload
//   memory_data_t    MEM/WB register payload
//   dbus_req_t       data-bus request
//   dbus_resp_t      data-bus response
//   is_aligned()     natural-alignment test used by the stage assertion
package common;

  localparam int BUS_ADDR_W = 64;
  localparam int BUS_DATA_W = 64;
  localparam int BUS_LANES  = BUS_DATA_W / 8;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic   reg_write;
    logic   mem_read;
    logic   mem_write;
    logic   mem_unsigned;
    msize_t msize;
  } ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] result;
    logic [63:0] store_data;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic        is_bubble;
  } execute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] result;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic        is_bubble;
  } memory_data_t;

  typedef struct packed {
    logic                  valid;
    logic [BUS_ADDR_W-1:0] addr;
    msize_t                size;
    logic [BUS_LANES-1:0]  strobe;
    logic [BUS_DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                  addr_ok;
    logic                  data_ok;
    logic [BUS_DATA_W-1:0] data;
  } dbus_resp_t;

  // True when the low address bits are a multiple of the access size.
  function automatic logic is_aligned(input logic [2:0] off, input msize_t size);
    case (size)
      MSIZE1:  is_aligned = 1'b1;
      MSIZE2:  is_aligned = (off[0] == 1'b0);
      MSIZE4:  is_aligned = (off[1:0] == 2'b00);
      default: is_aligned = (off == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane alignment for the MEM stage.
// Ports:
//   size_i        access size
//   off_i         byte offset within the 64-bit bus word (address[2:0])
//   store_data_i  register value to store (right-aligned)
//   unsigned_i    1 = zero-extend loads, 0 = sign-extend
//   rdata_i       captured bus read word
//   strobe_o      byte-enable mask for stores
//   wdata_o       store data shifted onto its byte lanes
//   load_data_o   extracted and extended load value
module mem_align
  import common::*;
(
  input  msize_t      size_i,
  input  logic [2:0]  off_i,
  input  logic [63:0] store_data_i,
  input  logic        unsigned_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  strobe_o,
  output logic [63:0] wdata_o,
  output logic [63:0] load_data_o
);

  logic [7:0]  base_mask;
  logic [5:0]  bit_off;
  logic [63:0] raw;

  assign bit_off = {off_i, 3'b000};

  always_comb begin
    case (size_i)
      MSIZE1:  base_mask = 8'h01;
      MSIZE2:  base_mask = 8'h03;
      MSIZE4:  base_mask = 8'h0f;
      default: base_mask = 8'hff;
    endcase
  end

  // Mask width is 8, so lanes shifted past byte 7 fall off the top.
  assign strobe_o = base_mask << off_i;
  assign wdata_o  = store_data_i << bit_off;
  assign raw      = rdata_i >> bit_off;

  always_comb begin
    case (size_i)
      MSIZE1:  load_data_o = unsigned_i ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      MSIZE2:  load_data_o = unsigned_i ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      MSIZE4:  load_data_o = unsigned_i ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: load_data_o = raw;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage in-order core.
// Issues data-bus requests for loads/stores arriving from the EX/MEM register,
// waits for the response, and hands the result to the MEM/WB register.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   dataE_in    EX/MEM payload (held stable by upstream while dwait=1)
//   iwait       fetch stall; the pipeline is frozen while high
//   dreq        data-bus request (valid held until data_ok)
//   dresp       data-bus response (addr_ok is informational only)
//   dataM_out   MEM/WB payload; a bubble while an access is outstanding
//   dwait       high while an access is in flight, freezing upstream
module memory_stage
  import common::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE_in,
  input  logic          iwait,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM_out,
  output logic          dwait
);

  mem_state_t        state_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_op;
  logic              req_active;
  logic [7:0]        strobe_calc;
  logic [63:0]       wdata_calc;
  logic [63:0]       load_data;

  assign mem_op = !dataE_in.is_bubble && (dataE_in.ctl.mem_read || dataE_in.ctl.mem_write);

  mem_align u_align (
    .size_i       (dataE_in.ctl.msize),
    .off_i        (dataE_in.result[2:0]),
    .store_data_i (dataE_in.store_data),
    .unsigned_i   (dataE_in.ctl.mem_unsigned),
    .rdata_i      (rdata_q),
    .strobe_o     (strobe_calc),
    .wdata_o      (wdata_calc),
    .load_data_o  (load_data)
  );

  // DONE exists so the instruction still sitting in EX/MEM (held by iwait)
  // is not issued a second time; we only return to IDLE on the edge where
  // the pipeline actually advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            if (dresp.data_ok) begin
              rdata_q <= dresp.data;
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dresp.data_ok) begin
            rdata_q <= dresp.data;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!iwait) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request/stall are combinational so a new access starts in its first
  // cycle; reset masks them immediately.
  always_comb begin
    req_active = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:    req_active = mem_op;
        WAIT:    req_active = 1'b1;
        default: req_active = 1'b0;
      endcase
    end
  end

  assign dwait = req_active;

  always_comb begin
    dreq        = '0;
    dreq.valid  = req_active;
    dreq.addr   = dataE_in.result[ADDR_W-1:0];
    dreq.size   = dataE_in.ctl.msize;
    dreq.strobe = (req_active && dataE_in.ctl.mem_write) ? strobe_calc : 8'h00;
    dreq.data   = wdata_calc;
  end

  always_comb begin
    dataM_out           = '0;
    dataM_out.pc        = dataE_in.pc;
    dataM_out.ctl       = dataE_in.ctl;
    dataM_out.dst       = dataE_in.dst;
    dataM_out.result    = dataE_in.ctl.mem_read ? load_data : dataE_in.result;
    dataM_out.is_bubble = reset || dataE_in.is_bubble || dwait;
  end

  // Misaligned accesses are a contract violation by the producer.
  a_aligned: assert property (@(posedge clk) disable iff (reset)
    dreq.valid |-> is_aligned(dreq.addr[2:0], dreq.size));

  // A well-behaved slave only acknowledges an address while a request is up.
  a_addr_ok: assert property (@(posedge clk) disable iff (reset)
    dresp.addr_ok |-> dreq.valid);

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  import common::*;

  logic          clk;
  logic          reset;
  execute_data_t dataE;
  logic          iwait;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  memory_data_t  dataM;
  logic          dwait;

  int n_cmp = 0;
  int n_bad = 0;

  memory_stage dut (
    .clk       (clk),
    .reset     (reset),
    .dataE_in  (dataE),
    .iwait     (iwait),
    .dreq      (dreq),
    .dresp     (dresp),
    .dataM_out (dataM),
    .dwait     (dwait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic bub, input logic rd, input logic wr, input logic uns,
                        input msize_t sz, input logic [63:0] res, input logic [63:0] sdata);
    dataE.pc               = 64'h8000_0000 + res;
    dataE.result           = res;
    dataE.store_data       = sdata;
    dataE.ctl.reg_write    = rd;
    dataE.ctl.mem_read     = rd;
    dataE.ctl.mem_write    = wr;
    dataE.ctl.mem_unsigned = uns;
    dataE.ctl.msize        = sz;
    dataE.dst              = 5'd7;
    dataE.is_bubble        = bub;
  endtask

  // Load acknowledged in its first cycle; result checked in DONE.
  task automatic do_load(input string tag, input msize_t sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] bus, input logic [63:0] exp);
    set_op(1'b0, 1'b1, 1'b0, uns, sz, addr, 64'd0);
    dresp.data_ok = 1'b1;
    dresp.data    = bus;
    #1;
    check_eq({tag, ".valid"}, 64'(dreq.valid), 64'd1);
    cyc();
    dresp.data_ok = 1'b0;
    dresp.data    = 64'd0;
    #1;
    check_eq({tag, ".result"}, dataM.result, exp);
    cyc();
  endtask

  task automatic do_store(input string tag, input msize_t sz, input logic [63:0] addr,
                          input logic [63:0] sdata, input logic [7:0] exp_strb, input logic [63:0] exp_data);
    set_op(1'b0, 1'b0, 1'b1, 1'b0, sz, addr, sdata);
    dresp.data_ok = 1'b1;
    #1;
    check_eq({tag, ".strobe"}, 64'(dreq.strobe), 64'(exp_strb));
    check_eq({tag, ".data"}, dreq.data, exp_data);
    cyc();
    dresp.data_ok = 1'b0;
    #1;
    check_eq({tag, ".dwait_done"}, 64'(dwait), 64'd0);
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    iwait = 1'b0;
    dresp = '0;
    // A live store during reset must still be suppressed.
    set_op(1'b0, 1'b0, 1'b1, 1'b0, MSIZE4, 64'h1004, 64'hdeadbeef);
    cyc();
    cyc();
    check_eq("rst.valid", 64'(dreq.valid), 64'd0);
    check_eq("rst.strobe", 64'(dreq.strobe), 64'd0);
    check_eq("rst.dwait", 64'(dwait), 64'd0);
    check_eq("rst.bubble", 64'(dataM.is_bubble), 64'd1);

    // ALU op passes straight through.
    reset = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, MSIZE8, 64'h1234, 64'd0);
    #1;
    check_eq("alu.valid", 64'(dreq.valid), 64'd0);
    check_eq("alu.dwait", 64'(dwait), 64'd0);
    check_eq("alu.result", dataM.result, 64'h1234);
    check_eq("alu.bubble", 64'(dataM.is_bubble), 64'd0);
    cyc();

    // sw at offset 4, data_ok on the 4th cycle of the request.
    set_op(1'b0, 1'b0, 1'b1, 1'b0, MSIZE4, 64'h1004, 64'hdeadbeef);
    for (int i = 0; i < 4; i++) begin
      dresp.data_ok = (i == 3);
      #1;
      check_eq($sformatf("sw.dwait%0d", i), 64'(dwait), 64'd1);
      check_eq($sformatf("sw.valid%0d", i), 64'(dreq.valid), 64'd1);
      check_eq($sformatf("sw.strobe%0d", i), 64'(dreq.strobe), 64'hf0);
      check_eq($sformatf("sw.data%0d", i), dreq.data, 64'hdeadbeef_00000000);
      check_eq($sformatf("sw.bubble%0d", i), 64'(dataM.is_bubble), 64'd1);
      cyc();
    end
    dresp.data_ok = 1'b0;
    #1;
    check_eq("sw.done_valid", 64'(dreq.valid), 64'd0);
    check_eq("sw.done_dwait", 64'(dwait), 64'd0);
    check_eq("sw.done_bubble", 64'(dataM.is_bubble), 64'd0);
    check_eq("sw.done_result", dataM.result, 64'h1004);
    cyc();

    // lb signed, acknowledged same cycle: WAIT skipped, one request only.
    set_op(1'b0, 1'b1, 1'b0, 1'b0, MSIZE1, 64'h2003, 64'd0);
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h0000_0000_8000_0000;
    #1;
    check_eq("lb.valid", 64'(dreq.valid), 64'd1);
    check_eq("lb.strobe", 64'(dreq.strobe), 64'd0);
    check_eq("lb.dwait", 64'(dwait), 64'd1);
    cyc();
    dresp.data_ok = 1'b0;
    dresp.data    = 64'd0;
    #1;
    check_eq("lb.done_valid", 64'(dreq.valid), 64'd0);
    check_eq("lb.done_dwait", 64'(dwait), 64'd0);
    check_eq("lb.done_bubble", 64'(dataM.is_bubble), 64'd0);
    check_eq("lb.result", dataM.result, 64'hffff_ffff_ffff_ff80);
    cyc();

    // lbu, then held in DONE by iwait with a stray data_ok.
    set_op(1'b0, 1'b1, 1'b0, 1'b1, MSIZE1, 64'h2003, 64'd0);
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h0000_0000_8000_0000;
    #1;
    check_eq("lbu.valid", 64'(dreq.valid), 64'd1);
    cyc();
    dresp.data = 64'hffff_ffff_ffff_ffff;
    iwait      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq($sformatf("lbu.hold_valid%0d", i), 64'(dreq.valid), 64'd0);
      check_eq($sformatf("lbu.hold_dwait%0d", i), 64'(dwait), 64'd0);
      check_eq($sformatf("lbu.hold_result%0d", i), dataM.result, 64'h80);
      cyc();
    end
    iwait         = 1'b0;
    dresp.data_ok = 1'b0;
    #1;
    check_eq("lbu.release_result", dataM.result, 64'h80);
    check_eq("lbu.release_valid", 64'(dreq.valid), 64'd0);
    cyc();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, MSIZE8, 64'h55, 64'd0);
    #1;
    check_eq("after_lbu.valid", 64'(dreq.valid), 64'd0);
    check_eq("after_lbu.result", dataM.result, 64'h55);
    cyc();

    do_load("lh", MSIZE2, 1'b0, 64'h3006, 64'h8001_0000_0000_0000, 64'hffff_ffff_ffff_8001);
    do_load("lwu", MSIZE4, 1'b1, 64'h3004, 64'hfedc_ba98_1111_1111, 64'h0000_0000_fedc_ba98);
    do_load("lw", MSIZE4, 1'b0, 64'h3004, 64'hfedc_ba98_1111_1111, 64'hffff_ffff_fedc_ba98);
    do_load("ld", MSIZE8, 1'b0, 64'h3000, 64'h0123_4567_89ab_cdef, 64'h0123_4567_89ab_cdef);
    do_store("sb", MSIZE1, 64'h4005, 64'h0000_0000_0000_00ab, 8'h20, 64'h0000_ab00_0000_0000);
    do_store("sh", MSIZE2, 64'h4002, 64'h0000_0000_0000_beef, 8'h0c, 64'h0000_0000_beef_0000);
    do_store("sd", MSIZE8, 64'h4000, 64'h1122_3344_5566_7788, 8'hff, 64'h1122_3344_5566_7788);

    // Reset while in WAIT.
    set_op(1'b0, 1'b1, 1'b0, 1'b0, MSIZE8, 64'h5000, 64'd0);
    #1;
    check_eq("rw.valid", 64'(dreq.valid), 64'd1);
    cyc();
    #1;
    check_eq("rw.wait_dwait", 64'(dwait), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("rw.rst_valid", 64'(dreq.valid), 64'd0);
    check_eq("rw.rst_dwait", 64'(dwait), 64'd0);
    check_eq("rw.rst_bubble", 64'(dataM.is_bubble), 64'd1);
    cyc();
    reset = 1'b0;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, MSIZE8, 64'd0, 64'd0);
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hdead_dead_dead_dead;
    #1;
    check_eq("rw.after_valid", 64'(dreq.valid), 64'd0);
    check_eq("rw.after_dwait", 64'(dwait), 64'd0);
    check_eq("rw.after_bubble", 64'(dataM.is_bubble), 64'd1);
    cyc();
    // Stray data_ok must have left the FSM in IDLE: a new load issues at once.
    set_op(1'b0, 1'b1, 1'b0, 1'b1, MSIZE1, 64'h5001, 64'd0);
    dresp.data_ok = 1'b0;
    dresp.data    = 64'd0;
    #1;
    check_eq("rw.new_valid", 64'(dreq.valid), 64'd1);
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h0000_0000_0000_7700;
    cyc();
    dresp.data_ok = 1'b0;
    #1;
    check_eq("rw.new_result", dataM.result, 64'h77);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
